// File: rtl/rv_mc_sequencer.sv
// rtl/rv_mc_sequencer.sv - multi-cycle RV32I control sequencer with handshaked fetch and data access
module rv_mc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic [XLEN-1:0]     imem_addr,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    input  logic [XLEN-1:0]     imm,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    output logic [4:0]          rd_addr,
    output logic                reg_wren,
    output logic [1:0]          wb_sel,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [XLEN-1:0]     alu_result,
    input  logic                alu_zero,
    input  logic                alu_lt,
    input  logic                alu_ltu,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ack,
    output logic                retire,
    output logic                halted,
    output logic [1:0]          trap_cause
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
    } state_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(9);

    localparam logic [1:0] SRC_A_PC  = 2'd0;
    localparam logic [1:0] SRC_A_RS1 = 2'd1;
    localparam logic [1:0] SRC_B_RS2 = 2'd0;
    localparam logic [1:0] SRC_B_IMM = 2'd1;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_DMEM = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [1:0] CAUSE_ILLEGAL    = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd2;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic opcode_legal;
    logic writes_rd;
    logic [1:0] wb_sel_dec;

    logic            branch_taken;
    logic            branch_bad_f3;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            target_misaligned;

    function automatic logic [ALU_OP_W-1:0] f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? OP_SUB : OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return alt ? OP_SRA : OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    assign imem_addr = pc;
    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];
    assign rd_addr   = instr[11:7];
    assign rs1_addr  = instr[19:15];
    assign rs2_addr  = instr[24:20];

    assign is_r      = (opcode == OPC_R);
    assign is_i      = (opcode == OPC_I);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);

    assign opcode_legal = is_r | is_i | is_load | is_store | is_branch
                        | is_jal | is_jalr | is_lui | is_auipc;
    assign writes_rd    = is_r | is_i | is_load | is_jal | is_jalr | is_lui | is_auipc;

    always_comb begin
        wb_sel_dec = WB_ALU;
        if (is_load)
            wb_sel_dec = WB_DMEM;
        else if (is_jal || is_jalr)
            wb_sel_dec = WB_PC4;
        else if (is_lui)
            wb_sel_dec = WB_IMM;
    end

    // ALU controls stay valid through MEM so the data address and store data remain stable.
    always_comb begin
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_RS2;
        alu_op    = OP_ADD;
        if (state == S_EXECUTE || state == S_MEM) begin
            if (is_r) begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = f3_op(funct3, funct7_b5);
            end else if (is_i) begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = f3_op(funct3, (funct3 == 3'b101) && funct7_b5);
            end else if (is_load || is_store || is_jalr) begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end else if (is_branch) begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = OP_SUB;
            end else if (is_auipc || is_jal || is_lui) begin
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_IMM;
            end
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = alu_zero;
            3'b001:  branch_taken = !alu_zero;
            3'b100:  branch_taken = alu_lt;
            3'b101:  branch_taken = !alu_lt;
            3'b110:  branch_taken = alu_ltu;
            3'b111:  branch_taken = !alu_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    assign branch_bad_f3 = is_branch && (funct3 == 3'b010 || funct3 == 3'b011);
    assign pc_imm        = pc + imm;
    assign jalr_target   = alu_result & ~XLEN'(1);

    always_comb begin
        target   = pc_plus4;
        redirect = 1'b0;
        if (is_jal || (is_branch && branch_taken)) begin
            target   = pc_imm;
            redirect = 1'b1;
        end else if (is_jalr) begin
            target   = jalr_target;
            redirect = 1'b1;
        end
    end

    assign target_misaligned = redirect && (target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            pc_plus4   <= '0;
            next_pc    <= '0;
            instr      <= 32'h0000_0013;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            reg_wren   <= 1'b0;
            retire     <= 1'b0;
            wb_sel     <= WB_ALU;
            halted     <= 1'b0;
            trap_cause <= 2'd0;
        end else begin
            reg_wren <= 1'b0;
            retire   <= 1'b0;
            case (state)
                S_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    pc_plus4 <= pc + XLEN'(4);
                    if (!opcode_legal) begin
                        halted     <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                        state      <= S_TRAP;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (branch_bad_f3) begin
                        halted     <= 1'b1;
                        trap_cause <= CAUSE_ILLEGAL;
                        state      <= S_TRAP;
                    end else if (target_misaligned) begin
                        halted     <= 1'b1;
                        trap_cause <= CAUSE_MISALIGNED;
                        state      <= S_TRAP;
                    end else begin
                        next_pc <= target;
                        if (is_load || is_store) begin
                            dmem_req <= 1'b1;
                            dmem_we  <= is_store;
                            state    <= S_MEM;
                        end else begin
                            reg_wren <= writes_rd;
                            retire   <= 1'b1;
                            wb_sel   <= wb_sel_dec;
                            state    <= S_WRITEBACK;
                        end
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        reg_wren <= is_load;
                        retire   <= 1'b1;
                        wb_sel   <= wb_sel_dec;
                        state    <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    pc       <= next_pc;
                    wb_sel   <= WB_ALU;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// tb/tb_rv_mc_sequencer.sv - randomized bench for rv_mc_sequencer against an instruction-level model
module tb_rv_mc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        reg_wren;
    logic [1:0]  wb_sel, alu_src_a, alu_src_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero, alu_lt, alu_ltu;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        retire, halted;
    logic [1:0]  trap_cause;

    rv_mc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .ALU_OP_W(4)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .reg_wren(reg_wren), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .retire(retire), .halted(halted), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        bit          ill;
        bit          mis;
        bit          check_alu;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] op;
        bit          wren;
        logic [31:0] wbs;
        bit          mem;
        bit          st;
        logic [31:0] npc;
    } exp_t;

    // kind index: R, I, load, store, branch, JAL, JALR, LUI, AUIPC; 9 = illegal
    logic [6:0] opc_tbl [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    int         op_tbl  [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mpc;
    bit          trapped;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (pc 0x%08h)", tag, got, exp, mpc);
        end
    endtask

    function automatic int kind_of(input logic [6:0] opc);
        for (int i = 0; i < 9; i++)
            if (opc_tbl[i] == opc) return i;
        return 9;
    endfunction

    function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] immv,
                                     input logic [31:0] alur, input bit z, input bit lt,
                                     input bit ltu, input logic [31:0] pc);
        exp_t e;
        logic [2:0] f3;
        bit alt, taken;
        e = '{default: 0};
        e.kind = kind_of(ins[6:0]);
        f3 = ins[14:12];
        alt = ins[30];
        e.npc = pc + 32'd4;
        e.check_alu = (e.kind != 7) && (e.kind != 9);
        e.src_a = 1;
        e.src_b = 1;
        e.op = 0;
        case (e.kind)
            0: begin
                e.src_b = 0;
                e.op = (f3 == 3'd0 && alt) ? 1 : (f3 == 3'd5 && alt) ? 7 : op_tbl[f3];
                e.wren = 1; e.wbs = 0;
            end
            1: begin
                e.op = (f3 == 3'd5 && alt) ? 7 : op_tbl[f3];
                e.wren = 1; e.wbs = 0;
            end
            2: begin e.mem = 1; e.wren = 1; e.wbs = 1; end
            3: begin e.mem = 1; e.st = 1; end
            4: begin
                e.src_b = 0;
                e.op = 1;
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1;
                else begin
                    taken = (f3 == 0) ? z : (f3 == 1) ? !z : (f3 == 4) ? lt :
                            (f3 == 5) ? !lt : (f3 == 6) ? ltu : !ltu;
                    if (taken) e.npc = pc + immv;
                end
            end
            5: begin e.src_a = 0; e.npc = pc + immv; e.wren = 1; e.wbs = 2; end
            6: begin e.npc = {alur[31:1], 1'b0}; e.wren = 1; e.wbs = 2; end
            7: begin e.wren = 1; e.wbs = 3; end
            8: begin e.src_a = 0; e.wren = 1; e.wbs = 0; end
            default: e.ill = 1;
        endcase
        e.mis = !e.ill && (e.kind >= 4 && e.kind <= 6) && (e.npc[1:0] != 2'b00);
        return e;
    endfunction

    task automatic expect_trap(input logic [31:0] cause);
        for (int k = 0; k < 3; k++) begin
            check("trap_halted", halted, 1);
            check("trap_cause", trap_cause, cause);
            check("trap_imem_req", imem_req, 0);
            check("trap_dmem_req", dmem_req, 0);
            check("trap_wren", reg_wren, 0);
            check("trap_retire", retire, 0);
            check("trap_pc", imem_addr, mpc);
            @(negedge clk);
        end
        trapped = 1;
    endtask

    // Entered and left at a negedge with the DUT in FETCH for the instruction at mpc.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] immv, input logic [31:0] alur,
                             input bit z, input bit lt, input bit ltu, input int iw, input int dw);
        exp_t e;
        e = predict(ins, immv, alur, z, lt, ltu, mpc);
        imm = immv; alu_result = alur; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
        imem_rdata = ins;
        for (int k = 0; k <= iw; k++) begin
            check("fetch_req", imem_req, 1);
            check("fetch_addr", imem_addr, mpc);
            check("fetch_retire", retire, 0);
            imem_ack = (k == iw);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        check("decode_req", imem_req, 0);
        check("decode_halted", halted, 0);
        @(negedge clk);
        if (e.kind == 9) begin
            expect_trap(1);
            return;
        end
        check("instr", instr, ins);
        check("rd_addr", rd_addr, ins[11:7]);
        check("rs1_addr", rs1_addr, ins[19:15]);
        check("rs2_addr", rs2_addr, ins[24:20]);
        if (e.check_alu) begin
            check("exe_src_a", alu_src_a, e.src_a);
            check("exe_src_b", alu_src_b, e.src_b);
            check("exe_alu_op", alu_op, e.op);
        end
        @(negedge clk);
        if (e.ill || e.mis) begin
            expect_trap(e.ill ? 1 : 2);
            return;
        end
        if (e.mem) begin
            for (int k = 0; k <= dw; k++) begin
                check("mem_req", dmem_req, 1);
                check("mem_we", dmem_we, e.st);
                check("mem_alu_op", alu_op, 0);
                check("mem_src_a", alu_src_a, 1);
                check("mem_src_b", alu_src_b, 1);
                check("mem_retire", retire, 0);
                dmem_ack = (k == dw);
                @(negedge clk);
            end
            dmem_ack = 1'b0;
        end
        check("wb_retire", retire, 1);
        check("wb_reg_wren", reg_wren, e.wren);
        if (e.wren) check("wb_sel", wb_sel, e.wbs);
        check("wb_dmem_req", dmem_req, 0);
        @(negedge clk);
        mpc = e.npc;
        check("next_fetch_req", imem_req, 1);
        check("next_pc", imem_addr, mpc);
        check("retire_once", retire, 0);
        check("wren_once", reg_wren, 0);
    endtask

    task automatic do_reset();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mpc = 32'h0;
        check("idle_req", imem_req, 0);
        check("idle_halted", halted, 0);
        check("idle_cause", trap_cause, 0);
        check("idle_pc", imem_addr, 32'h0);
        @(negedge clk);
        trapped = 0;
    endtask

    task automatic reset_in_mem();
        imem_rdata = 32'h0000_A103;
        imm = 32'h0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rim_dmem_req", dmem_req, 1);
        reset = 1'b1;
        #1;
        check("rim_dmem_req_drop", dmem_req, 0);
        check("rim_pc", imem_addr, 32'h0);
        check("rim_retire", retire, 0);
        check("rim_wren", reg_wren, 0);
        @(negedge clk);
        reset = 1'b0;
        mpc = 32'h0;
        check("rim_idle_req", imem_req, 0);
        @(negedge clk);
        check("rim_fetch_req", imem_req, 1);
        check("rim_fetch_addr", imem_addr, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins, immv, alur;
        int kind;
        reset = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0; imm = 32'h0;
        alu_result = 32'h0; alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; dmem_ack = 1'b0;
        mpc = 32'h0;
        trapped = 0;
        repeat (2) @(negedge clk);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_wren", reg_wren, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        check("rst_cause", trap_cause, 0);
        check("rst_wb_sel", wb_sel, 0);
        check("rst_alu", {alu_src_a, alu_src_b, alu_op}, 0);
        check("rst_pc", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        reset = 1'b0;
        check("rst_idle_req", imem_req, 0);
        @(negedge clk);

        run_instr(32'h0050_0093, 32'd5, 32'd5, 0, 0, 0, 0, 0);
        run_instr(32'h0000_A103, 32'd0, 32'h40, 0, 0, 0, 3, 2);
        run_instr(32'h0000_0013, 32'd0, 32'd0, 0, 0, 0, 0, 0);
        run_instr(32'h0000_0013, 32'd0, 32'd0, 0, 0, 0, 1, 0);
        check("pc_at_0x10", mpc, 32'h10);
        run_instr(32'h0000_0063, 32'hFFFF_FFF8, 32'd0, 1, 0, 0, 0, 0);
        check("beq_taken_pc", mpc, 32'h08);
        run_instr(32'h0000_0063, 32'd8, 32'd0, 1, 0, 0, 0, 0);
        run_instr(32'h0000_0063, 32'hFFFF_FFF8, 32'd0, 0, 0, 0, 0, 0);
        check("beq_not_taken_pc", mpc, 32'h14);
        run_instr(32'h0000_7063, 32'h40, 32'd0, 0, 0, 1, 0, 0);
        check("bgeu_not_taken_pc", mpc, 32'h18);
        run_instr(32'h0000_80E7, 32'd0, 32'h101, 0, 0, 0, 0, 0);
        check("jalr_pc", mpc, 32'h100);
        run_instr(32'h0000_80E7, 32'd0, 32'h103, 0, 0, 0, 0, 0);
        check("jalr_misaligned_trapped", trapped, 1);
        do_reset();
        run_instr(32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0, 0, 2, 0);
        check("illegal_trapped", trapped, 1);
        do_reset();
        run_instr(32'h0050_0093, 32'd5, 32'd5, 0, 0, 0, 0, 0);
        reset_in_mem();

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            ins = $urandom;
            if (kind < 9) begin
                ins[6:0] = opc_tbl[kind];
            end else begin
                while (kind_of(ins[6:0]) != 9) ins[6:0] = 7'($urandom);
            end
            immv = $urandom;
            if ($urandom_range(0, 3) != 0) immv[1:0] = 2'b00;
            alur = $urandom;
            if ($urandom_range(0, 3) != 0) alur[1] = 1'b0;
            run_instr(ins, immv, alur, 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            if (trapped) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mc_sequencer.md
Name: rv_mc_sequencer

Overview:
Parametrised multi-cycle control sequencer for the RV32I core; owns the PC, the instruction register and all datapath control. It replaces the fixed six-state loop with ready/ack handshakes on both memories, so variable-latency memories can stall the core. It adds JALR, LUI and AUIPC support, branch/jump target generation and an illegal-instruction/misalignment trap. It sits between the memory module, register file, ALU and imm_gen inside the top level.

Parameters:
XLEN, 32, datapath width (PC, ALU result, immediate)
RESET_PC, 0, PC value loaded on reset
ALU_OP_W, 4, width of alu_op

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
imem_addr  out  XLEN  fetch address (= PC)
imem_req  out  1  fetch request, held until ack
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
instr  out  32  instruction register, to imm_gen
imm  in  XLEN  immediate from imm_gen
rs1_addr / rs2_addr / rd_addr  out  5 each  register file indices, from instr
reg_wren  out  1  register file write enable, one-cycle pulse
wb_sel  out  2  0 ALU, 1 dmem, 2 PC+4, 3 imm
alu_src_a  out  2  0 PC, 1 rs1
alu_src_b  out  2  0 rs2, 1 imm, 2 const 4
alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
alu_result  in  XLEN  ALU output
alu_zero / alu_lt / alu_ltu  in  1 each  ALU flags
dmem_req  out  1  data access request, held until ack
dmem_we  out  1  store when high, qualified by dmem_req
dmem_ack  in  1  data access complete
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  high in TRAP
trap_cause  out  2  0 none, 1 illegal opcode, 2 misaligned target

Behaviour:
- Reset is asynchronous: state=IDLE, pc=RESET_PC, instr=0x00000013 (NOP), and every output 0 (trap_cause=0).
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- IDLE -> FETCH unconditionally after one cycle.
- FETCH: imem_req=1, imem_addr=pc. Stay until imem_ack. On ack, instr<=imem_rdata and go to DECODE. Ack in the first FETCH cycle (zero wait) is legal.
- DECODE: latch pc_plus4 = pc+4 (internal adder, mod 2^XLEN). Check the opcode; any opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} -> TRAP with cause 1. Otherwise -> EXECUTE.
- EXECUTE: drive alu_src/alu_op combinationally from instr.
  - R-type: rs1/rs2, op from funct3/funct7[5].
  - I-type: rs1/imm; funct3=101 uses funct7[5] for SRA; SUB is never selected.
  - Load/store/JALR: rs1+imm ADD.
  - Branch: rs1-rs2 SUB.
  - AUIPC: PC+imm.
  - JAL: PC+imm.
  - Register next_pc:
    - Branch taken (BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu): pc+imm; not taken: pc_plus4.
    - JAL: pc+imm.
    - JALR: alu_result with bit0 cleared.
    - All others: pc_plus4.
  - Branch funct3 010/011 -> TRAP cause 1.
  - A taken or jump target with bits[1:0]!=0 -> TRAP cause 2; PC is not updated.
  - Load/store -> MEM; all others -> WRITEBACK.
- MEM: dmem_req=1; dmem_we=1 for store. Address and store data come from the datapath (ALU result, rs2), held stable because alu_src/alu_op are held. Stay until dmem_ack, then -> WRITEBACK.
- WRITEBACK:
  - reg_wren=1 for R, I, load, JAL, JALR, LUI, AUIPC; never for store or branch.
  - wb_sel: ALU (R, I, AUIPC), dmem (load), PC+4 (JAL, JALR), imm (LUI).
  - pc<=next_pc; retire=1; -> FETCH.
  - rd=0 still pulses reg_wren; the register file ignores x0.
- TRAP: halted=1, all requests/enables 0, PC frozen at the faulting instruction. Exit only via reset.
- Latency with zero-wait memories: 4 cycles per non-memory instruction, 5 per load/store. Each wait cycle on imem_ack/dmem_ack adds 1.
- Reset asserted mid-handshake aborts immediately; no write or retire occurs.

Test Plan:
- Zero-wait: ADDI x1,x0,5 at RESET_PC=0 -> reg_wren in cycle 4 after FETCH entry, wb_sel=0, alu_op=0, pc=4, retire pulses once.
- Wait states: imem_ack delayed 3 cycles, then LW with dmem_ack delayed 2 -> imem_req and dmem_req held steady throughout, retire 9 cycles after fetch start, wb_sel=1.
- Branches:
  - BEQ at pc=0x10, imm=-8, alu_zero=1 -> pc=0x08.
  - Same with alu_zero=0 -> pc=0x14.
  - BGEU with alu_ltu=1 -> not taken.
- JALR: alu_result=0x103 -> pc=0x102 traps cause 2 (misaligned), halted=1, no reg_wren. alu_result=0x101 -> pc=0x100, wb_sel=2, reg_wren.
- Illegal: instr=0xFFFFFFFF -> TRAP cause 1 after DECODE, all requests 0, PC unchanged.
- Async reset: assert reset during MEM with dmem_req=1 -> dmem_req=0 the same cycle, pc=RESET_PC, state IDLE.
